// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding req/gnt/rvalid fetch into a small {pc, instr} FIFO.
// Optional FETCH_ALIGN_CHECK_EN adds a registered misalign_o pulse for misaligned redirect targets.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [6:0]  op_o,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic        misalign_o,
`endif
   output logic [1:0]  dbg_state_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_DISCARD = 2'd3;

   logic [1:0]    r_state;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_req_pc;
   logic [AW:0]   r_count;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [31:0]   r_pc_mem    [DEPTH];
   logic [31:0]   r_instr_mem [DEPTH];

   logic [1:0]  w_state_nxt;
   logic [AW:0] w_count_nxt;
   logic        w_push;
   logic        w_pop;

   // Handshakes: memory accepts a request on imem_req_o & imem_gnt_i; downstream takes
   // the FIFO head on valid_o & ready_i. Neither side may withdraw data it has offered.
   assign w_push = (r_state == S_WAIT) && imem_rvalid_i && !redirect_i;
   assign w_pop  = valid_o && ready_i;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   // A request is only launched when its response is guaranteed a FIFO slot.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (!redirect_i && (r_count < DEPTH_C)) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (imem_gnt_i) w_state_nxt = redirect_i ? S_DISCARD : S_WAIT;
         end
         S_WAIT: begin
            if (redirect_i) begin
               w_state_nxt = imem_rvalid_i ? S_IDLE : S_DISCARD;
            end else if (imem_rvalid_i) begin
               w_state_nxt = (w_count_nxt < DEPTH_C) ? S_REQ : S_IDLE;
            end
         end
         S_DISCARD: begin
            if (imem_rvalid_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         if (redirect_i) begin
            r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
         end else if ((r_state == S_REQ) && imem_gnt_i) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if ((r_state == S_REQ) && imem_gnt_i) r_req_pc <= r_fetch_pc;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pc_mem[i]    <= '0;
            r_instr_mem[i] <= '0;
         end
      end else if (redirect_i) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         r_count <= w_count_nxt;
         if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_req_pc;
            r_instr_mem[r_wr_ptr] <= imem_rdata_i;
            r_wr_ptr              <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   assign imem_req_o  = (r_state == S_REQ);
   assign imem_addr_o = r_fetch_pc;
   assign valid_o     = (r_count != '0);
   assign instr_o     = r_instr_mem[r_rd_ptr];
   assign pc_o        = r_pc_mem[r_rd_ptr];
   assign op_o        = instr_o[6:0];
   assign dbg_state_o = r_state;

`ifdef FETCH_ALIGN_CHECK_EN
   logic r_misalign;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
      end
   end

   assign misalign_o = r_misalign;
`else
   logic w_unused_pc_lsb;
   assign w_unused_pc_lsb = ^redirect_pc_i[1:0];
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: bench-side memory responder, transaction-level expected-output queue,
// and directed scenarios for back-pressure, redirects, address wrap and mid-transaction reset.
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic [6:0]  op_o;
   logic [1:0]  dbg_state_unused;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalign_o;
   logic        exp_mis = 1'b0;
`endif

   instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .op_o          (op_o),
`ifdef FETCH_ALIGN_CHECK_EN
      .misalign_o    (misalign_o),
`endif
      .dbg_state_o   (dbg_state_unused)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Expected presented stream, each entry {pc, instr}.
   logic [63:0] exp_q[$];
   logic [63:0] pop_log[$];
   logic [31:0] grant_log[$];
   logic [31:0] model_pc = RESET_PC;

   // Bench memory: one response slot.
   bit          slot_busy  = 0;
   int          slot_cnt   = 0;
   logic [31:0] slot_pc    = '0;
   logic [31:0] slot_data  = '0;
   bit          slot_stale = 0;
   int          lat        = 1;
   bit          gnt_en     = 1;
   bit          force_bad  = 0;
   bit          bad_sent   = 0;
   int          bad_cyc    = 0;
   int          stale_rv   = 0;
   bit          last_gnt   = 0;
   bit          last_rv    = 0;
   logic [31:0] last_gnt_addr = '0;
   int          last_gnt_cyc  = 0;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a * 32'h9E37_79B9 + 32'h0000_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic check_cycle();
      chk("valid_o", 32'(valid_o), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("pc_o", pc_o, exp_q[0][63:32]);
         chk("instr_o", instr_o, exp_q[0][31:0]);
         chk("op_o", 32'(op_o), 32'(exp_q[0][6:0]));
      end
      if (imem_req_o) chk("credit", 32'(exp_q.size() < DEPTH), 32'd1);
      if (imem_gnt_i) chk("imem_addr_o", imem_addr_o, model_pc);
      chk("addr_align", 32'(imem_addr_o[1:0]), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("misalign_o", 32'(misalign_o), 32'(exp_mis));
`endif
   endtask

   task automatic update_model();
      bit do_rst;
      bit do_rd;
      do_rst   = rst_i;
      do_rd    = redirect_i;
      last_gnt = imem_gnt_i;
      last_rv  = imem_rvalid_i;
      if (imem_gnt_i) begin
         last_gnt_addr = imem_addr_o;
         last_gnt_cyc  = cyc;
         grant_log.push_back(imem_addr_o);
      end
      if (!do_rst && valid_o && ready_i) begin
         pop_log.push_back({pc_o, instr_o});
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (imem_rvalid_i) begin
         if (force_bad) begin
            bad_sent  = 1;
            bad_cyc   = cyc;
            force_bad = 0;
         end
         if (slot_stale) stale_rv++;
         else if (!do_rst && !do_rd) exp_q.push_back({slot_pc, imem_rdata_i});
         slot_busy = 0;
      end else if (slot_busy) begin
         slot_cnt--;
      end
      if (do_rst || do_rd) begin
         exp_q.delete();
         if (slot_busy) slot_stale = 1;
      end
      if (imem_gnt_i) begin
         slot_busy  = 1;
         slot_cnt   = lat;
         slot_pc    = model_pc;
         slot_data  = instr_of(model_pc);
         slot_stale = do_rst || do_rd;
      end
      if (do_rst) model_pc = RESET_PC;
      else if (do_rd) model_pc = {redirect_pc_i[31:2], 2'b00};
      else if (imem_gnt_i) model_pc = model_pc + 32'd4;
`ifdef FETCH_ALIGN_CHECK_EN
      exp_mis = !do_rst && do_rd && (redirect_pc_i[1:0] != 2'b00);
`endif
   endtask

   // One clock cycle: drive memory side, check mid-cycle, advance the model, cross the edge.
   task automatic step();
      imem_gnt_i    = imem_req_o && gnt_en && !slot_busy;
      imem_rvalid_i = slot_busy && (slot_cnt == 1);
      imem_rdata_i  = '0;
      if (imem_rvalid_i) imem_rdata_i = force_bad ? 32'hDEAD_BEEF : slot_data;
      #2;
      check_cycle();
      update_model();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_until_grant(input string name, input int max_cyc, output logic [31:0] addr);
      bit got;
      got  = 0;
      addr = '0;
      for (int i = 0; i < max_cyc && !got; i++) begin
         step();
         if (last_gnt) begin
            got  = 1;
            addr = last_gnt_addr;
         end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL %s: no grant within %0d cycles", name, max_cyc);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"}, 32'(imem_req_o), 32'd0);
      chk({tag, "_addr"}, imem_addr_o, RESET_PC);
      chk({tag, "_valid"}, 32'(valid_o), 32'd0);
      chk({tag, "_instr"}, instr_o, 32'd0);
      chk({tag, "_pc"}, pc_o, 32'd0);
      chk({tag, "_op"}, 32'(op_o), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk({tag, "_misalign"}, 32'(misalign_o), 32'd0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          rd_cyc;
      int          nbad;
      int          rv_before;

      rst_i = 1; ready_i = 1; redirect_i = 0; redirect_pc_i = '0;
      imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
      @(posedge clk);
      #1;

      // Reset release, immediate grant, 1-cycle latency, always ready.
      run(2);
      chk_reset_outputs("rst0");
      rst_i = 0;
      grant_log.delete();
      pop_log.delete();
      step();
      chk("c1_req", 32'(imem_req_o), 32'd1);
      chk("c1_addr", imem_addr_o, RESET_PC);
      run(13);
      chk("seq_addr0", grant_log[0], 32'h0);
      chk("seq_addr1", grant_log[1], 32'h4);
      chk("seq_addr2", grant_log[2], 32'h8);
      chk("first_pc", pop_log[0][63:32], 32'h0);
      chk("first_instr", pop_log[0][31:0], 32'h0000_0013);
      chk("first_op", 32'(pop_log[0][6:0]), 32'b0010011);
      chk("second_pc", pop_log[1][63:32], 32'h4);
      chk("throughput", 32'(pop_log.size()), 32'd6);

      // Back-pressure: exactly DEPTH grants, then no request; drain in order.
      ready_i = 0;
      rst_i   = 1;
      step();
      rst_i = 0;
      grant_log.delete();
      pop_log.delete();
      run(10);
      chk("bp_grants", 32'(grant_log.size()), 32'(DEPTH));
      chk("bp_req_low", 32'(imem_req_o), 32'd0);
      chk("bp_valid", 32'(valid_o), 32'd1);
      ready_i = 1;
      run(10);
      for (int i = 0; i < pop_log.size(); i++) chk("drain_order", pop_log[i][63:32], 32'(4 * i));
      chk("drain_count_min", 32'(pop_log.size() >= 4), 32'd1);

      // Redirect during WAIT; stale response 0xDEADBEEF two cycles later.
      rst_i = 1;
      step();
      rst_i = 0;
      lat   = 3;
      pop_log.delete();
      run_until_grant("t3_first_grant", 10, a);
      redirect_i    = 1;
      redirect_pc_i = 32'h0000_0100;
      force_bad     = 1;
      rd_cyc        = cyc;
      step();
      redirect_i = 0;
      chk("t3_valid_after_redirect", 32'(valid_o), 32'd0);
      run_until_grant("t3_redirect_grant", 12, a);
      chk("t3_redirect_addr", a, 32'h0000_0100);
      chk("t3_bad_sent", 32'(bad_sent), 32'd1);
      chk("t3_bad_delay", 32'(bad_cyc - rd_cyc), 32'd2);
      chk("t3_discard_gap", 32'(last_gnt_cyc - bad_cyc), 32'd2);
      lat = 1;
      run(12);
      chk("t3_first_pc", pop_log[0][63:32], 32'h0000_0100);
      nbad = 0;
      foreach (pop_log[i]) if (pop_log[i][31:0] == 32'hDEAD_BEEF) nbad++;
      chk("t3_no_deadbeef", 32'(nbad), 32'd0);

      // Redirect in the cycle of rvalid with the FIFO about to fill.
      ready_i = 0;
      rst_i   = 1;
      step();
      rst_i = 0;
      grant_log.delete();
      for (int i = 0; i < 12 && grant_log.size() < 2; i++) step();
      chk("t4_two_grants", 32'(grant_log.size()), 32'd2);
      chk("t4_valid_before", 32'(valid_o), 32'd1);
      redirect_i    = 1;
      redirect_pc_i = 32'h0000_0300;
      step();
      redirect_i = 0;
      chk("t4_rvalid_same_cycle", 32'(last_rv), 32'd1);
      chk("t4_empty", 32'(valid_o), 32'd0);
      ready_i = 1;
      pop_log.delete();
      run_until_grant("t4_grant", 10, a);
      chk("t4_addr", a, 32'h0000_0300);
      run(6);
      chk("t4_first_pc", pop_log[0][63:32], 32'h0000_0300);

      // Address wrap at the top of the address space.
      redirect_i    = 1;
      redirect_pc_i = 32'hFFFF_FFF8;
      step();
      redirect_i = 0;
      grant_log.delete();
      run(12);
      chk("wrap0", grant_log[0], 32'hFFFF_FFF8);
      chk("wrap1", grant_log[1], 32'hFFFF_FFFC);
      chk("wrap2", grant_log[2], 32'h0000_0000);

      // Misaligned redirect target: fetch proceeds from the aligned address.
      redirect_i    = 1;
      redirect_pc_i = 32'h0000_0102;
      step();
      redirect_i = 0;
      grant_log.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_pulse", 32'(misalign_o), 32'd1);
`endif
      step();
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_clear", 32'(misalign_o), 32'd0);
`endif
      run(8);
      chk("mis_fetch_addr", grant_log[0], 32'h0000_0100);

      // Redirect while a request waits for grant: address switches next cycle.
      gnt_en = 0;
      for (int i = 0; i < 20 && !imem_req_o; i++) step();
      chk("t6_in_req", 32'(imem_req_o), 32'd1);
      redirect_i    = 1;
      redirect_pc_i = 32'h0000_0400;
      step();
      redirect_i = 0;
      chk("t6_req_held", 32'(imem_req_o), 32'd1);
      chk("t6_addr", imem_addr_o, 32'h0000_0400);
      gnt_en = 1;
      run_until_grant("t6_grant", 5, a);
      chk("t6_grant_addr", a, 32'h0000_0400);

      // Reset while waiting for a response; the late response must be ignored.
      lat = 3;
      run(6);
      run_until_grant("t7_grant", 12, a);
      rv_before = stale_rv;
      rst_i = 1;
      step();
      rst_i = 0;
      chk_reset_outputs("t7_rst");
      grant_log.delete();
      run(10);
      chk("t7_late_rvalid_seen", 32'(stale_rv - rv_before), 32'd1);
      chk("t7_restart_addr", grant_log[0], RESET_PC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
